// File: rtl/clk_div_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// clk_div_if : rate-select handshake and divided-clock outputs
// Revision   : 1.0
// ---------------------------------------------------------------------------
interface clk_div_if;
    logic       en;
    logic [2:0] cfg_div;
    logic       cfg_req;
    logic       cfg_ack;
    logic       cfg_err;
    logic       busy;
    logic [2:0] cur_div;
    logic       clk_out;
    logic       clk_tick;

    modport master (
        output en, cfg_div, cfg_req,
        input  cfg_ack, cfg_err, busy, cur_div, clk_out, clk_tick
    );

    modport slave (
        input  en, cfg_div, cfg_req,
        output cfg_ack, cfg_err, busy, cur_div, clk_out, clk_tick
    );
endinterface
`default_nettype wire

// File: rtl/clk_div_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// clk_div_ctrl : power-of-two clock divider with glitch-free ratio changes
// Revision     : 1.0
// ---------------------------------------------------------------------------
module clk_div_ctrl #(
    parameter int unsigned DEFAULT_DIV = 5,
    parameter int unsigned SETTLE      = 4
) (
    input  wire logic  clk_in,
    input  wire logic  resetb,
    clk_div_if.slave   bus
);

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_PENDING = 2'd1,
        ST_SETTLE  = 2'd2
    } state_t;

    localparam logic [2:0] C_MAX_DIV     = 3'd5;
    localparam logic [2:0] C_RESET_DIV   = 3'(DEFAULT_DIV);
    localparam logic [3:0] C_SETTLE_LAST = 4'(SETTLE - 1);

    function automatic logic [5:0] div_half(input logic [2:0] d);
        return 6'd1 << d;
    endfunction

    // Wraps to 63 for d=5 because the shifted half overflows to zero.
    function automatic logic [5:0] div_mask(input logic [2:0] d);
        return (div_half(d) << 1) - 6'd1;
    endfunction

    logic [5:0] cc_q,       cc_d;
    logic [2:0] cur_div_q,  cur_div_d;
    logic [2:0] pend_div_q, pend_div_d;
    logic [3:0] settle_q,   settle_d;
    state_t     state_q,    state_d;
    logic       clk_out_q,  clk_out_d;
    logic       clk_tick_q, clk_tick_d;
    logic       busy_q,     busy_d;
    logic       ack_q,      ack_d;
    logic       err_q,      err_d;
    logic [5:0] cc_shift;

    always_comb begin
        cc_d       = cc_q;
        cur_div_d  = cur_div_q;
        pend_div_d = pend_div_q;
        settle_d   = settle_q;
        state_d    = state_q;
        ack_d      = 1'b0;
        err_d      = 1'b0;

        if (bus.en) begin
            cc_d = cc_q + 6'd1;
            case (state_q)
                ST_RUN: begin
                    if (bus.cfg_req) begin
                        if (bus.cfg_div <= C_MAX_DIV) begin
                            pend_div_d = bus.cfg_div;
                            state_d    = ST_PENDING;
                        end else begin
                            err_d = 1'b1;
                        end
                    end
                end
                ST_PENDING: begin
                    // Terminal cycle sits in the high half, so restarting at 0 never makes a runt.
                    if ((cc_q & div_mask(cur_div_q)) == div_mask(cur_div_q)) begin
                        cc_d      = 6'd0;
                        cur_div_d = pend_div_q;
                        settle_d  = 4'd0;
                        state_d   = ST_SETTLE;
                    end
                end
                ST_SETTLE: begin
                    settle_d = settle_q + 4'd1;
                    if (settle_q == C_SETTLE_LAST) begin
                        ack_d   = 1'b1;
                        state_d = ST_RUN;
                    end
                end
                default: state_d = ST_RUN;
            endcase
        end

        cc_shift   = cc_d >> cur_div_d;
        clk_out_d  = cc_shift[0];
        clk_tick_d = bus.en && ((cc_d & div_mask(cur_div_d)) == div_half(cur_div_d));
        busy_d     = (state_d != ST_RUN);
    end

    always_ff @(posedge clk_in) begin
        if (!resetb) begin
            cc_q       <= 6'd0;
            cur_div_q  <= C_RESET_DIV;
            pend_div_q <= C_RESET_DIV;
            settle_q   <= 4'd0;
            state_q    <= ST_RUN;
            clk_out_q  <= 1'b0;
            clk_tick_q <= 1'b0;
            busy_q     <= 1'b0;
            ack_q      <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            cc_q       <= cc_d;
            cur_div_q  <= cur_div_d;
            pend_div_q <= pend_div_d;
            settle_q   <= settle_d;
            state_q    <= state_d;
            clk_out_q  <= clk_out_d;
            clk_tick_q <= clk_tick_d;
            busy_q     <= busy_d;
            ack_q      <= ack_d;
            err_q      <= err_d;
        end
    end

    assign bus.clk_out  = clk_out_q;
    assign bus.clk_tick = clk_tick_q;
    assign bus.busy     = busy_q;
    assign bus.cur_div  = cur_div_q;
    assign bus.cfg_ack  = ack_q;
    assign bus.cfg_err  = err_q;

endmodule
`default_nettype wire

// File: tb/tb_clk_div_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_clk_div_ctrl : scenario tasks with an ack/err event scoreboard
// Revision        : 1.0
// ---------------------------------------------------------------------------
module tb_clk_div_ctrl;

    localparam int C_SETTLE = 4;

    logic clk_in;
    logic resetb;
    clk_div_if bus ();

    clk_div_ctrl #(
        .DEFAULT_DIV(5),
        .SETTLE     (C_SETTLE)
    ) dut (
        .clk_in(clk_in),
        .resetb(resetb),
        .bus   (bus.slave)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    typedef struct {
        int cyc;
        int div;
    } ev_t;

    ev_t ack_exp[$];
    int  err_exp[$];
    int  cyc;
    int  n_en;
    int  vectors;
    int  miscompares;

    // {clk_out, clk_tick, cur_div} after m enabled cycles into a period of ratio div
    function automatic logic [4:0] exp_out(input int m, input int div);
        int p;
        p = 2 << div;
        return {((m % p) >= p / 2), ((m % p) == p / 2), 3'(div)};
    endfunction

    // Old ratio is always the reset ratio (5) in these scenarios.
    function automatic logic [4:0] exp_vec(input int n, input int sw, input int nd);
        if (sw < 0 || n < sw) return exp_out(n, 5);
        return exp_out(n - sw, nd);
    endfunction

    function automatic int next_term(input int r);
        int t;
        t = r + 1;
        while (t % 64 != 63) t++;
        return t;
    endfunction

    task automatic do_reset();
        resetb      = 1'b0;
        bus.en      = 1'b0;
        bus.cfg_req = 1'b0;
        bus.cfg_div = 3'd0;
        repeat (3) @(posedge clk_in);
        @(negedge clk_in);
        resetb = 1'b1;
        cyc    = 0;
        n_en   = 0;
        ack_exp.delete();
        err_exp.delete();
    endtask

    task automatic step();
        if (bus.en && resetb) n_en++;
        @(negedge clk_in);
        cyc++;
        while (ack_exp.size() > 0 && ack_exp[0].cyc < cyc) begin
            vectors++; miscompares++;
            $display("FAIL ack_missing cyc=%0d got=none exp_cyc=%0d", cyc, ack_exp[0].cyc);
            void'(ack_exp.pop_front());
        end
        if (bus.cfg_ack) begin
            vectors++;
            if (ack_exp.size() == 0) begin
                miscompares++;
                $display("FAIL ack_unexpected cyc=%0d got=ack exp=none", cyc);
            end else if (ack_exp[0].cyc != cyc || int'(bus.cur_div) != ack_exp[0].div) begin
                miscompares++;
                $display("FAIL ack_event got cyc=%0d div=%0d exp cyc=%0d div=%0d",
                         cyc, bus.cur_div, ack_exp[0].cyc, ack_exp[0].div);
                void'(ack_exp.pop_front());
            end else begin
                void'(ack_exp.pop_front());
            end
        end
        while (err_exp.size() > 0 && err_exp[0] < cyc) begin
            vectors++; miscompares++;
            $display("FAIL err_missing cyc=%0d got=none exp_cyc=%0d", cyc, err_exp[0]);
            void'(err_exp.pop_front());
        end
        if (bus.cfg_err) begin
            vectors++;
            if (err_exp.size() == 0 || err_exp[0] != cyc) begin
                miscompares++;
                $display("FAIL err_event cyc=%0d got=err exp_cyc=%0d", cyc,
                         (err_exp.size() > 0) ? err_exp[0] : -1);
            end
            if (err_exp.size() > 0) void'(err_exp.pop_front());
        end
    endtask

    task automatic sb_drain(input string name);
        while (ack_exp.size() > 0) begin
            vectors++; miscompares++;
            $display("FAIL %s ack_never got=none exp_cyc=%0d", name, ack_exp[0].cyc);
            void'(ack_exp.pop_front());
        end
        while (err_exp.size() > 0) begin
            vectors++; miscompares++;
            $display("FAIL %s err_never got=none exp_cyc=%0d", name, err_exp[0]);
            void'(err_exp.pop_front());
        end
    endtask

    task automatic test_reset();
        logic [7:0] got;
        do_reset();
        resetb = 1'b0;
        @(negedge clk_in);
        got = {bus.clk_out, bus.clk_tick, bus.cur_div, bus.busy, bus.cfg_ack, bus.cfg_err};
        vectors++;
        if (got !== 8'b0_0_101_0_0_0) begin
            miscompares++;
            $display("FAIL reset_values got=%b exp=%b", got, 8'b0_0_101_0_0_0);
        end
        do_reset();
    endtask

    task automatic test_free_run();
        logic [5:0] got, exp;
        do_reset();
        bus.en = 1'b1;
        for (int k = 0; k < 200; k++) begin
            got = {bus.clk_out, bus.clk_tick, bus.cur_div, bus.busy};
            exp = {exp_vec(n_en, -1, 5), 1'b0};
            vectors++;
            if (got !== exp) begin
                miscompares++;
                $display("FAIL free_run cyc=%0d got=%b exp=%b", cyc, got, exp);
            end
            step();
        end
        sb_drain("free_run");
    endtask

    task automatic test_switch();
        logic [5:0] got, exp;
        int sw;
        do_reset();
        bus.en = 1'b1;
        sw = next_term(10) + 1;
        for (int k = 0; k < 120; k++) begin
            got = {bus.clk_out, bus.clk_tick, bus.cur_div, bus.busy};
            exp = {exp_vec(n_en, sw, 1), (cyc > 10 && n_en < sw + C_SETTLE)};
            vectors++;
            if (got !== exp) begin
                miscompares++;
                $display("FAIL switch cyc=%0d got=%b exp=%b", cyc, got, exp);
            end
            bus.cfg_req = (k == 10);
            bus.cfg_div = 3'd1;
            if (k == 10) ack_exp.push_back('{sw + C_SETTLE, 1});
            step();
        end
        bus.cfg_req = 1'b0;
        sb_drain("switch");
    endtask

    task automatic test_invalid();
        logic [5:0] got, exp;
        do_reset();
        bus.en = 1'b1;
        for (int k = 0; k < 100; k++) begin
            got = {bus.clk_out, bus.clk_tick, bus.cur_div, bus.busy};
            exp = {exp_vec(n_en, -1, 5), 1'b0};
            vectors++;
            if (got !== exp) begin
                miscompares++;
                $display("FAIL invalid cyc=%0d got=%b exp=%b", cyc, got, exp);
            end
            bus.cfg_req = (k == 20 || k == 40);
            bus.cfg_div = (k == 20) ? 3'd7 : 3'd6;
            if (k == 20 || k == 40) err_exp.push_back(k + 1);
            step();
        end
        bus.cfg_req = 1'b0;
        sb_drain("invalid");
    endtask

    task automatic test_busy_ignore();
        logic [5:0] got, exp;
        int sw;
        do_reset();
        bus.en = 1'b1;
        sw = next_term(5) + 1;
        for (int k = 0; k < 110; k++) begin
            got = {bus.clk_out, bus.clk_tick, bus.cur_div, bus.busy};
            exp = {exp_vec(n_en, sw, 2), (cyc > 5 && n_en < sw + C_SETTLE)};
            vectors++;
            if (got !== exp) begin
                miscompares++;
                $display("FAIL busy_ignore cyc=%0d got=%b exp=%b", cyc, got, exp);
            end
            bus.cfg_req = (k == 5 || k == 30 || k == 66);
            bus.cfg_div = (k == 5) ? 3'd2 : ((k == 30) ? 3'd0 : 3'd7);
            if (k == 5) ack_exp.push_back('{sw + C_SETTLE, 2});
            step();
        end
        bus.cfg_req = 1'b0;
        sb_drain("busy_ignore");
    endtask

    task automatic test_en_freeze();
        logic [5:0] got, exp;
        int sw;
        do_reset();
        bus.en = 1'b1;
        sw = next_term(10) + 1;
        for (int k = 0; k < 130; k++) begin
            got = {bus.clk_out, bus.clk_tick, bus.cur_div, bus.busy};
            exp = {exp_vec(n_en, sw, 1), (cyc > 10 && n_en < sw + C_SETTLE)};
            vectors++;
            if (got !== exp) begin
                miscompares++;
                $display("FAIL en_freeze cyc=%0d got=%b exp=%b", cyc, got, exp);
            end
            bus.en      = !(k >= 40 && k < 60);
            bus.cfg_req = (k == 10);
            bus.cfg_div = 3'd1;
            if (k == 10) ack_exp.push_back('{sw + C_SETTLE + 20, 1});
            step();
        end
        bus.cfg_req = 1'b0;
        sb_drain("en_freeze");
    endtask

    task automatic test_reset_settle();
        logic [5:0] got, exp;
        int sw;
        do_reset();
        bus.en = 1'b1;
        sw = next_term(10) + 1;
        for (int k = 0; k < 76; k++) begin
            got = {bus.clk_out, bus.clk_tick, bus.cur_div, bus.busy};
            if (k <= 66) exp = {exp_vec(n_en, sw, 3), (cyc > 10 && n_en < sw + C_SETTLE)};
            else         exp = 6'b0_0_101_0;
            vectors++;
            if (got !== exp) begin
                miscompares++;
                $display("FAIL reset_settle cyc=%0d got=%b exp=%b", cyc, got, exp);
            end
            bus.cfg_req = (k == 10);
            bus.cfg_div = 3'd3;
            resetb      = (k < 66);
            step();
        end
        bus.cfg_req = 1'b0;
        resetb      = 1'b1;
        cyc         = 0;
        n_en        = 0;
        for (int k = 0; k < 100; k++) begin
            got = {bus.clk_out, bus.clk_tick, bus.cur_div, bus.busy};
            exp = {exp_vec(n_en, -1, 5), 1'b0};
            vectors++;
            if (got !== exp) begin
                miscompares++;
                $display("FAIL reset_abort cyc=%0d got=%b exp=%b", cyc, got, exp);
            end
            step();
        end
        sb_drain("reset_settle");
    endtask

    task automatic test_boundary_req();
        logic [5:0] got, exp;
        int sw;
        do_reset();
        bus.en = 1'b1;
        sw = next_term(63) + 1;
        for (int k = 0; k < 150; k++) begin
            got = {bus.clk_out, bus.clk_tick, bus.cur_div, bus.busy};
            exp = {exp_vec(n_en, sw, 0), (cyc > 63 && n_en < sw + C_SETTLE)};
            vectors++;
            if (got !== exp) begin
                miscompares++;
                $display("FAIL boundary_req cyc=%0d got=%b exp=%b", cyc, got, exp);
            end
            bus.cfg_req = (k == 63);
            bus.cfg_div = 3'd0;
            if (k == 63) ack_exp.push_back('{sw + C_SETTLE, 0});
            step();
        end
        bus.cfg_req = 1'b0;
        sb_drain("boundary_req");
    endtask

    task automatic test_same_ratio();
        logic [5:0] got, exp;
        int sw;
        do_reset();
        bus.en = 1'b1;
        sw = next_term(140) + 1;
        for (int k = 0; k < 220; k++) begin
            got = {bus.clk_out, bus.clk_tick, bus.cur_div, bus.busy};
            exp = {exp_vec(n_en, sw, 5), (cyc > 140 && n_en < sw + C_SETTLE)};
            vectors++;
            if (got !== exp) begin
                miscompares++;
                $display("FAIL same_ratio cyc=%0d got=%b exp=%b", cyc, got, exp);
            end
            bus.cfg_req = (k == 140);
            bus.cfg_div = 3'd5;
            if (k == 140) ack_exp.push_back('{sw + C_SETTLE, 5});
            step();
        end
        bus.cfg_req = 1'b0;
        sb_drain("same_ratio");
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        test_reset();
        test_free_run();
        test_switch();
        test_invalid();
        test_busy_ignore();
        test_en_freeze();
        test_reset_settle();
        test_boundary_req();
        test_same_ratio();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
